// File: rtl/relu_array_pipe.sv
// Two-stage ReLU-family activation unit over NUM_CH signed lanes with valid/ready flow control.
// S1 applies the per-lane activation; S2 applies the clip bound and saturates to OUT_W.
module relu_array_pipe #(
    parameter int NUM_CH     = 4,
    parameter int IN_W       = 12,
    parameter int OUT_W      = 12,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                mode,
    input  logic signed [OUT_W-1:0]   clip_max,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_CH*IN_W-1:0]    in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_CH*OUT_W-1:0]   out_data,
    output logic [NUM_CH-1:0]         zero_mask
);

    // Common width that holds both an input sample and the clip bound without overflow.
    localparam int CW = ((IN_W > OUT_W) ? IN_W : OUT_W) + 1;
    localparam logic signed [CW-1:0] SAT_MAX = CW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [CW-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic signed [IN_W:0] activate(input logic signed [IN_W-1:0] x,
                                                      input logic [1:0] m);
        logic signed [IN_W-1:0] y;
        case (m)
            2'd0, 2'd2: y = (!x[IN_W-1] && (x != '0)) ? x : '0;
            2'd1:       y = x[IN_W-1] ? (x >>> LEAK_SHIFT) : x;
            default:    y = x;
        endcase
        return {y[IN_W-1], y};
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [CW-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[OUT_W-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[OUT_W-1:0];
        else
            return v[OUT_W-1:0];
    endfunction

    function automatic logic signed [OUT_W-1:0] finish_lane(input logic signed [IN_W:0] a,
                                                            input logic [1:0] m,
                                                            input logic signed [OUT_W-1:0] c);
        logic signed [CW-1:0] y;
        logic signed [CW-1:0] ce;
        y  = CW'(a);
        ce = CW'(c);
        if ((m == 2'd2) && (y > ce))
            y = ce;
        return saturate(y);
    endfunction

    logic                      vld_p1;
    logic                      vld_p2;
    logic signed [IN_W:0]      act_p1 [NUM_CH];
    logic [1:0]                mode_p1;
    logic signed [OUT_W-1:0]   clip_p1;
    logic [NUM_CH*OUT_W-1:0]   data_p2;
    logic [NUM_CH-1:0]         zmask_p2;

    logic                      s1_adv;
    logic                      s2_adv;
    logic signed [IN_W:0]      act_nxt [NUM_CH];
    logic [NUM_CH*OUT_W-1:0]   data_nxt;
    logic [NUM_CH-1:0]         zmask_nxt;

    assign s2_adv    = !vld_p2 || out_ready;
    assign s1_adv    = !vld_p1 || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = vld_p2;
    assign out_data  = data_p2;
    assign zero_mask = zmask_p2;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++)
            act_nxt[k] = activate(in_data[k*IN_W +: IN_W], mode);
    end

    always_comb begin
        logic signed [OUT_W-1:0] lane;
        lane      = '0;
        data_nxt  = '0;
        zmask_nxt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            lane                      = finish_lane(act_p1[k], mode_p1, clip_p1);
            data_nxt[k*OUT_W +: OUT_W] = lane;
            zmask_nxt[k]              = (lane == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (s1_adv)
                vld_p1 <= in_valid;
            if (s2_adv)
                vld_p2 <= vld_p1;
        end
    end

    // S1 boundary: activation result, mode and non-negative clip bound
    always_ff @(posedge clk) begin
        if (in_valid && s1_adv) begin
            for (int k = 0; k < NUM_CH; k++)
                act_p1[k] <= act_nxt[k];
            mode_p1 <= mode;
            clip_p1 <= clip_max[OUT_W-1] ? '0 : clip_max;
        end
    end

    // S2 boundary: clipped, saturated lanes and zero flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_p2  <= '0;
            zmask_p2 <= '0;
        end else if (s2_adv && vld_p1) begin
            data_p2  <= data_nxt;
            zmask_p2 <= zmask_nxt;
        end
    end

endmodule

// File: tb/tb_relu_array_pipe.sv
// Scoreboard bench for relu_array_pipe: a 12-bit-output instance plus an 8-bit-output instance for saturation.
module tb_relu_array_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic signed [11:0] clip_max = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [47:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [47:0] out_data;
    logic [3:0]  zero_mask;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic signed [7:0] clip8 = '0;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [31:0] out_data8;
    logic [3:0]  zero_mask8;

    typedef struct {
        logic [47:0] d;
        logic [3:0]  z;
    } exp_t;

    exp_t q[$];
    exp_t q8[$];

    int tests = 0;
    int fails = 0;
    logic bp_en = 1'b0;
    logic or_fixed = 1'b0;
    int pidx = 0;
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    relu_array_pipe #(.NUM_CH(4), .IN_W(12), .OUT_W(12), .LEAK_SHIFT(3)) dut (
        .clk(clk), .rst(rst), .mode(mode), .clip_max(clip_max),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .zero_mask(zero_mask)
    );

    relu_array_pipe #(.NUM_CH(4), .IN_W(12), .OUT_W(8), .LEAK_SHIFT(3)) dut8 (
        .clk(clk), .rst(rst), .mode(mode), .clip_max(clip8),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .zero_mask(zero_mask8)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] p12(input int a, input int b, input int c, input int d);
        return {12'(d), 12'(c), 12'(b), 12'(a)};
    endfunction

    function automatic logic [31:0] p8(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic drive_or();
        out_ready = bp_en ? pat[pidx % 6] : or_fixed;
        pidx++;
    endtask

    // Called at a falling edge; returns at a later falling edge after acceptance.
    task automatic send(input logic [47:0] d, input logic [1:0] m, input logic signed [11:0] c,
                        input logic [47:0] ed, input logic [3:0] ez);
        exp_t e;
        int waited = 0;
        in_data = d; mode = m; clip_max = c; in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clk); drive_or(); #1;
            waited++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready stuck at 0, required 1");
        end else begin
            e.d = ed; e.z = ez;
            q.push_back(e);
        end
        @(negedge clk); drive_or();
        in_valid = 1'b0;
    endtask

    task automatic send8(input logic [47:0] d, input logic [1:0] m,
                         input logic [31:0] ed, input logic [3:0] ez);
        exp_t e;
        in_data = d; mode = m; in_valid8 = 1'b1;
        #1;
        chk("in_ready8", {63'd0, in_ready8}, 64'd1);
        e.d = {16'd0, ed}; e.z = ez;
        q8.push_back(e);
        @(negedge clk); drive_or();
        in_valid8 = 1'b0;
    endtask

    // Monitor for the 12-bit instance: handshake prediction, stall stability, in-order compare.
    initial begin
        int occ = 0;
        logic stall = 1'b0;
        logic [47:0] held = '0;
        logic acc, emit;
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                occ = 0; stall = 1'b0;
            end else begin
                acc  = in_valid && in_ready;
                emit = out_valid && out_ready;
                chk("in_ready_pred", {63'd0, in_ready}, {63'd0, (occ < 2) || out_ready});
                if (stall) begin
                    chk("stall_valid", {63'd0, out_valid}, 64'd1);
                    chk("stall_data", {16'd0, out_data}, {16'd0, held});
                end
                if (emit) begin
                    if (q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_beat: got %h expected none", out_data);
                    end else begin
                        e = q.pop_front();
                        chk("out_data", {16'd0, out_data}, {16'd0, e.d});
                        chk("zero_mask", {60'd0, zero_mask}, {60'd0, e.z});
                    end
                end
                stall = out_valid && !out_ready;
                held  = out_data;
                occ   = occ + int'(acc) - int'(emit);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (!rst && out_valid8 && out_ready8) begin
                if (q8.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_beat8: got %h expected none", out_data8);
                end else begin
                    e = q8.pop_front();
                    chk("out_data8", {32'd0, out_data8}, {16'd0, e.d});
                    chk("zero_mask8", {60'd0, zero_mask8}, {60'd0, e.z});
                end
            end
        end
    end

    initial begin
        int guard;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {16'd0, out_data}, 64'd0);
        chk("rst_zero_mask", {60'd0, zero_mask}, 64'd0);
        @(negedge clk);
        or_fixed = 1'b1; drive_or();

        send(p12(-2048, -1, 0, 2047), 2'd0, 12'sd0, p12(0, 0, 0, 2047), 4'b0111);
        send(p12(-8, -9, -1, 100), 2'd1, 12'sd0, p12(-1, -2, -1, 100), 4'b0000);
        send(p12(7, 6, 5, -3), 2'd2, 12'sd6, p12(6, 6, 5, 0), 4'b1000);
        send(p12(7, 6, 5, -3), 2'd2, -12'sd4, p12(0, 0, 0, 0), 4'b1111);
        send8(p12(2047, -2048, 127, -128), 2'd3, p8(127, -128, 127, -128), 4'b0000);
        send8(p12(2047, 100, -5, 200), 2'd0, p8(127, 100, 0, 127), 4'b0100);
        repeat (5) begin @(negedge clk); drive_or(); end
        chk("q_drained", q.size(), 64'd0);
        chk("q8_drained", q8.size(), 64'd0);

        // Two beats stuck in the pipe, then reset
        or_fixed = 1'b0; drive_or();
        send(p12(1, 2, 3, 4), 2'd3, 12'sd0, p12(1, 2, 3, 4), 4'b0000);
        send(p12(5, 6, 7, 8), 2'd3, 12'sd0, p12(5, 6, 7, 8), 4'b0000);
        #3 rst = 1'b1;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_out_data", {16'd0, out_data}, 64'd0);
        chk("midrst_zero_mask", {60'd0, zero_mask}, 64'd0);
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        or_fixed = 1'b1; drive_or();
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (4) begin @(negedge clk); drive_or(); end

        // Backpressured stream, one mode change per beat
        pidx = 0; bp_en = 1'b1; drive_or();
        send(p12(300, -300, 0, -1), 2'd0, 12'sd100, p12(300, 0, 0, 0), 4'b1110);
        send(p12(-16, -17, 16, 0), 2'd1, 12'sd100, p12(-2, -3, 16, 0), 4'b1000);
        send(p12(150, 100, 99, -7), 2'd2, 12'sd100, p12(100, 100, 99, 0), 4'b1000);
        send(p12(-2048, 2047, -5, 0), 2'd3, 12'sd100, p12(-2048, 2047, -5, 0), 4'b1000);
        send(p12(1, 2, 3, 4), 2'd0, 12'sd100, p12(1, 2, 3, 4), 4'b0000);
        send(p12(-2048, -100, -7, 2047), 2'd1, 12'sd100, p12(-256, -13, -1, 2047), 4'b0000);
        send(p12(2047, -2048, 50, 51), 2'd2, 12'sd50, p12(50, 0, 50, 50), 4'b0010);
        send(p12(11, -11, 22, -22), 2'd3, 12'sd100, p12(11, -11, 22, -22), 4'b0000);
        send(p12(-5, 5, -6, 6), 2'd0, 12'sd100, p12(0, 5, 0, 6), 4'b0101);
        send(p12(10, 20, -30, 0), 2'd2, -12'sd1, p12(0, 0, 0, 0), 4'b1111);

        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            @(negedge clk); drive_or();
            guard++;
        end
        bp_en = 1'b0; or_fixed = 1'b1; drive_or();
        repeat (6) begin @(negedge clk); drive_or(); end
        chk("final_q_empty", q.size(), 64'd0);
        chk("final_idle_valid", {63'd0, out_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
